// File: rtl/id_ex_stage.sv
// ID/EX pipeline register with hazard detection, operand-forward select and a stall counter.
// Define FORWARDING_EN for the forwarding policy; otherwise hazards are resolved by stalling.
module id_ex_stage (
  input  logic        clk,
  input  logic        reset,
  input  logic        id_valid,
  input  logic [31:0] id_pc,
  input  logic [31:0] id_imm,
  input  logic [31:0] id_rd1,
  input  logic [31:0] id_rd2,
  input  logic [4:0]  id_rs1,
  input  logic [4:0]  id_rs2,
  input  logic [4:0]  id_rd,
  input  logic        id_use_rs1,
  input  logic        id_use_rs2,
  input  logic        id_reg_write,
  input  logic        id_mem_read,
  input  logic [15:0] id_ctrl,
  input  logic        ex_flush,
  input  logic [4:0]  mem_rd,
  input  logic [4:0]  wb_rd,
  input  logic        mem_reg_write,
  input  logic        wb_reg_write,
  output logic        stall_id,
  output logic        ex_valid,
  output logic        ex_reg_write,
  output logic        ex_mem_read,
  output logic [31:0] ex_pc,
  output logic [31:0] ex_imm,
  output logic [31:0] ex_rs1_data,
  output logic [31:0] ex_rs2_data,
  output logic [4:0]  ex_rs1,
  output logic [4:0]  ex_rs2,
  output logic [4:0]  ex_rd,
  output logic [15:0] ex_ctrl,
  output logic [1:0]  fwd_a,
  output logic [1:0]  fwd_b,
  output logic [15:0] stall_cnt
);

  logic ex_writer;
  logic hit_ex;
  logic hazard;

  // x0 is hard-wired zero, so a writer targeting it never creates a dependency
  assign ex_writer = ex_valid && ex_reg_write && (ex_rd != 5'd0);
  assign hit_ex    = ex_writer && ((id_use_rs1 && (id_rs1 == ex_rd)) ||
                                   (id_use_rs2 && (id_rs2 == ex_rd)));

`ifdef FORWARDING_EN
  function automatic logic [1:0] fwd_sel(input logic [4:0] rs,
                                         input logic [4:0] m_rd, input logic m_we,
                                         input logic [4:0] w_rd, input logic w_we);
    if (m_we && (m_rd != 5'd0) && (m_rd == rs))
      return 2'b01;
    else if (w_we && (w_rd != 5'd0) && (w_rd == rs))
      return 2'b10;
    else
      return 2'b00;
  endfunction

  // Only a load still in EX cannot be forwarded in time
  assign hazard = hit_ex && ex_mem_read;
  assign fwd_a  = fwd_sel(ex_rs1, mem_rd, mem_reg_write, wb_rd, wb_reg_write);
  assign fwd_b  = fwd_sel(ex_rs2, mem_rd, mem_reg_write, wb_rd, wb_reg_write);
`else
  logic mem_writer;
  logic hit_mem;
  logic unused_wb;

  assign mem_writer = mem_reg_write && (mem_rd != 5'd0);
  assign hit_mem    = mem_writer && ((id_use_rs1 && (id_rs1 == mem_rd)) ||
                                     (id_use_rs2 && (id_rs2 == mem_rd)));
  assign hazard     = hit_ex || hit_mem;
  assign fwd_a      = 2'b00;
  assign fwd_b      = 2'b00;
  assign unused_wb  = ^{wb_rd, wb_reg_write};
`endif

  assign stall_id = id_valid && !ex_flush && !reset && hazard;

  // Flush and stall both insert a bubble; the payload holds so only control bits change
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      ex_valid     <= 1'b0;
      ex_reg_write <= 1'b0;
      ex_mem_read  <= 1'b0;
      ex_pc        <= '0;
      ex_imm       <= '0;
      ex_rs1_data  <= '0;
      ex_rs2_data  <= '0;
      ex_rs1       <= '0;
      ex_rs2       <= '0;
      ex_rd        <= '0;
      ex_ctrl      <= '0;
    end else if (ex_flush || stall_id) begin
      ex_valid     <= 1'b0;
      ex_reg_write <= 1'b0;
      ex_mem_read  <= 1'b0;
    end else begin
      ex_valid     <= id_valid;
      ex_reg_write <= id_valid && id_reg_write;
      ex_mem_read  <= id_valid && id_mem_read;
      ex_pc        <= id_pc;
      ex_imm       <= id_imm;
      ex_rs1_data  <= id_rd1;
      ex_rs2_data  <= id_rd2;
      ex_rs1       <= id_rs1;
      ex_rs2       <= id_rs2;
      ex_rd        <= id_rd;
      ex_ctrl      <= id_ctrl;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset)
      stall_cnt <= '0;
    else if (stall_id && (stall_cnt != 16'hFFFF))
      stall_cnt <= stall_cnt + 16'd1;
  end

endmodule

// File: tb/tb_id_ex_stage.sv
// Self-checking bench for id_ex_stage: directed hazard scenarios plus randomized traffic
// compared against a behavioural model; honours FORWARDING_EN like the design.
module tb_id_ex_stage;

  logic        clk = 1'b0;
  logic        reset;
  logic        id_valid;
  logic [31:0] id_pc, id_imm, id_rd1, id_rd2;
  logic [4:0]  id_rs1, id_rs2, id_rd;
  logic        id_use_rs1, id_use_rs2, id_reg_write, id_mem_read;
  logic [15:0] id_ctrl;
  logic        ex_flush;
  logic [4:0]  mem_rd, wb_rd;
  logic        mem_reg_write, wb_reg_write;
  logic        stall_id, ex_valid, ex_reg_write, ex_mem_read;
  logic [31:0] ex_pc, ex_imm, ex_rs1_data, ex_rs2_data;
  logic [4:0]  ex_rs1, ex_rs2, ex_rd;
  logic [15:0] ex_ctrl;
  logic [1:0]  fwd_a, fwd_b;
  logic [15:0] stall_cnt;

  always #5 clk = ~clk;

  id_ex_stage dut (
    .clk(clk), .reset(reset),
    .id_valid(id_valid), .id_pc(id_pc), .id_imm(id_imm), .id_rd1(id_rd1), .id_rd2(id_rd2),
    .id_rs1(id_rs1), .id_rs2(id_rs2), .id_rd(id_rd),
    .id_use_rs1(id_use_rs1), .id_use_rs2(id_use_rs2),
    .id_reg_write(id_reg_write), .id_mem_read(id_mem_read), .id_ctrl(id_ctrl),
    .ex_flush(ex_flush), .mem_rd(mem_rd), .wb_rd(wb_rd),
    .mem_reg_write(mem_reg_write), .wb_reg_write(wb_reg_write),
    .stall_id(stall_id), .ex_valid(ex_valid), .ex_reg_write(ex_reg_write), .ex_mem_read(ex_mem_read),
    .ex_pc(ex_pc), .ex_imm(ex_imm), .ex_rs1_data(ex_rs1_data), .ex_rs2_data(ex_rs2_data),
    .ex_rs1(ex_rs1), .ex_rs2(ex_rs2), .ex_rd(ex_rd), .ex_ctrl(ex_ctrl),
    .fwd_a(fwd_a), .fwd_b(fwd_b), .stall_cnt(stall_cnt)
  );

  int checks_total  = 0;
  int checks_passed = 0;

  // Reference model of the EX slot contents and the number of stall cycles seen
  bit          m_valid, m_rw, m_mr;
  logic [31:0] m_pc, m_imm, m_rd1, m_rd2;
  logic [4:0]  m_rs1, m_rs2, m_rd;
  logic [15:0] m_ctrl;
  int          m_stalls;

  task automatic checkOutput(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks_total++;
    if (got === exp)
      checks_passed++;
    else
      $display("[TB] FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
  endtask

  task automatic model_reset();
    m_valid = 0; m_rw = 0; m_mr = 0;
    m_pc = 0; m_imm = 0; m_rd1 = 0; m_rd2 = 0;
    m_rs1 = 0; m_rs2 = 0; m_rd = 0; m_ctrl = 0;
    m_stalls = 0;
  endtask

  function automatic bit reads_from(input logic [4:0] wrd, input bit writer);
    if (!writer || wrd == 5'd0) return 0;
    return (id_use_rs1 && id_rs1 == wrd) || (id_use_rs2 && id_rs2 == wrd);
  endfunction

  function automatic bit exp_stall();
    bit ex_w;
    ex_w = m_valid && m_rw;
    if (reset || !id_valid || ex_flush) return 0;
`ifdef FORWARDING_EN
    return m_mr && reads_from(m_rd, ex_w);
`else
    return reads_from(m_rd, ex_w) || reads_from(mem_rd, mem_reg_write);
`endif
  endfunction

  function automatic logic [1:0] exp_fwd(input logic [4:0] rs);
`ifdef FORWARDING_EN
    if (mem_reg_write && mem_rd != 5'd0 && mem_rd == rs) return 2'b01;
    if (wb_reg_write && wb_rd != 5'd0 && wb_rd == rs) return 2'b10;
`endif
    return rs == 5'd31 && 1'b0 ? 2'b11 : 2'b00;
  endfunction

  task automatic clear_inputs();
    id_valid = 0; id_pc = 0; id_imm = 0; id_rd1 = 0; id_rd2 = 0;
    id_rs1 = 0; id_rs2 = 0; id_rd = 0; id_use_rs1 = 0; id_use_rs2 = 0;
    id_reg_write = 0; id_mem_read = 0; id_ctrl = 0; ex_flush = 0;
    mem_rd = 0; wb_rd = 0; mem_reg_write = 0; wb_reg_write = 0;
  endtask

  // One clock cycle with the current inputs: check combinational outputs, then registered ones
  task automatic applyStimulus();
    bit s;
    logic [31:0] exp_cnt;
    #1;
    s = exp_stall();
    checkOutput("stall_id", {31'd0, stall_id}, {31'd0, s});
    checkOutput("fwd_a", {30'd0, fwd_a}, {30'd0, exp_fwd(m_rs1)});
    checkOutput("fwd_b", {30'd0, fwd_b}, {30'd0, exp_fwd(m_rs2)});
    if (ex_flush || s) begin
      m_valid = 0; m_rw = 0; m_mr = 0;
    end else begin
      m_valid = id_valid; m_rw = id_valid && id_reg_write; m_mr = id_valid && id_mem_read;
      m_pc = id_pc; m_imm = id_imm; m_rd1 = id_rd1; m_rd2 = id_rd2;
      m_rs1 = id_rs1; m_rs2 = id_rs2; m_rd = id_rd; m_ctrl = id_ctrl;
    end
    if (s) m_stalls++;
    @(posedge clk);
    #1;
    exp_cnt = (m_stalls > 65535) ? 32'hFFFF : 32'(m_stalls);
    checkOutput("ex_valid", {31'd0, ex_valid}, {31'd0, m_valid});
    checkOutput("ex_reg_write", {31'd0, ex_reg_write}, {31'd0, m_rw});
    checkOutput("ex_mem_read", {31'd0, ex_mem_read}, {31'd0, m_mr});
    checkOutput("ex_pc", ex_pc, m_pc);
    checkOutput("ex_imm", ex_imm, m_imm);
    checkOutput("ex_rs1_data", ex_rs1_data, m_rd1);
    checkOutput("ex_rs2_data", ex_rs2_data, m_rd2);
    checkOutput("ex_regs", {17'd0, ex_rs1, ex_rs2, ex_rd}, {17'd0, m_rs1, m_rs2, m_rd});
    checkOutput("ex_ctrl", {16'd0, ex_ctrl}, {16'd0, m_ctrl});
    checkOutput("stall_cnt", {16'd0, stall_cnt}, exp_cnt);
    @(negedge clk);
  endtask

  task automatic set_writer(input logic [4:0] rd);
    clear_inputs();
    id_valid = 1; id_rd = rd; id_reg_write = 1; id_mem_read = 1;
    id_pc = 32'h200; id_ctrl = 16'hA5A5;
    applyStimulus();
  endtask

  task automatic set_reader(input logic [4:0] rs1, input bit use1, input logic [4:0] rs2, input bit use2);
    clear_inputs();
    id_valid = 1; id_rd = 5'd8; id_reg_write = 1;
    id_rs1 = rs1; id_use_rs1 = use1; id_rs2 = rs2; id_use_rs2 = use2;
    id_pc = 32'h204; id_rd1 = 32'h1111; id_rd2 = 32'h2222; id_ctrl = 16'h0F0F;
  endtask

  task automatic randomize_inputs();
    id_valid     = ($urandom_range(3) != 0);
    id_pc        = $urandom;
    id_imm       = $urandom;
    id_rd1       = $urandom;
    id_rd2       = $urandom;
    id_rs1       = 5'($urandom_range(3));
    id_rs2       = 5'($urandom_range(3));
    id_rd        = 5'($urandom_range(3));
    id_use_rs1   = ($urandom_range(1) == 1);
    id_use_rs2   = ($urandom_range(1) == 1);
    id_reg_write = ($urandom_range(4) < 3);
    id_mem_read  = ($urandom_range(2) == 0);
    id_ctrl      = 16'($urandom);
    ex_flush     = ($urandom_range(9) == 0);
    mem_rd       = 5'($urandom_range(3));
    wb_rd        = 5'($urandom_range(3));
    mem_reg_write = ($urandom_range(1) == 1);
    wb_reg_write  = ($urandom_range(1) == 1);
  endtask

  initial begin
    int cnt0;
    clear_inputs();
    model_reset();
    reset = 1;
    #12;
    checkOutput("reset_valid", {31'd0, ex_valid}, 32'd0);
    checkOutput("reset_cnt", {16'd0, stall_cnt}, 32'd0);
    @(negedge clk);
    reset = 0;

    // Back-to-back acceptance with no hazards
    clear_inputs();
    id_valid = 1; id_pc = 32'h100; id_rd = 5'd5; id_reg_write = 1;
    applyStimulus();
    checkOutput("bb_valid", {31'd0, ex_valid}, 32'd1);
    checkOutput("bb_pc", ex_pc, 32'h100);
    checkOutput("bb_rd", {27'd0, ex_rd}, 32'd5);

    // Dependency on a load in EX: stalls in both policies
    cnt0 = m_stalls;
    set_writer(5'd3);
    set_reader(5'd3, 1, 5'd0, 0);
    #1;
    checkOutput("lu_stall", {31'd0, stall_id}, 32'd1);
    applyStimulus();
    checkOutput("lu_bubble", {31'd0, ex_valid}, 32'd0);
    checkOutput("lu_cnt1", {16'd0, stall_cnt}, 32'(cnt0 + 1));
    mem_rd = 5'd3; mem_reg_write = 1;
`ifdef FORWARDING_EN
    #1;
    checkOutput("lu_release", {31'd0, stall_id}, 32'd0);
    applyStimulus();
    checkOutput("lu_cnt", {16'd0, stall_cnt}, 32'(cnt0 + 1));
    clear_inputs();
    wb_rd = 5'd3; wb_reg_write = 1;
    #1;
    checkOutput("lu_fwd_a", {30'd0, fwd_a}, 32'd2);
    applyStimulus();

    // ALU result dependency is forwarded, never stalled
    clear_inputs();
    id_valid = 1; id_rd = 5'd7; id_reg_write = 1;
    applyStimulus();
    set_reader(5'd0, 0, 5'd7, 1);
    #1;
    checkOutput("raw_stall", {31'd0, stall_id}, 32'd0);
    applyStimulus();
    clear_inputs();
    mem_rd = 5'd7; mem_reg_write = 1;
    #1;
    checkOutput("raw_fwd_mem", {30'd0, fwd_b}, 32'd1);
    wb_rd = 5'd7; wb_reg_write = 1;
    #1;
    checkOutput("raw_fwd_prio", {30'd0, fwd_b}, 32'd1);
    applyStimulus();
`else
    #1;
    checkOutput("st_mem_stall", {31'd0, stall_id}, 32'd1);
    applyStimulus();
    mem_reg_write = 0; wb_rd = 5'd3; wb_reg_write = 1;
    #1;
    checkOutput("st_release", {31'd0, stall_id}, 32'd0);
    checkOutput("st_fwd_a", {30'd0, fwd_a}, 32'd0);
    applyStimulus();
    checkOutput("st_cnt2", {16'd0, stall_cnt}, 32'(cnt0 + 2));
    checkOutput("st_enter", {31'd0, ex_valid}, 32'd1);
`endif

    // x0 destination and unused sources never stall
    set_writer(5'd0);
    set_reader(5'd0, 1, 5'd0, 1);
    #1;
    checkOutput("x0_stall", {31'd0, stall_id}, 32'd0);
    applyStimulus();
    set_writer(5'd6);
    set_reader(5'd1, 1, 5'd6, 0);
    #1;
    checkOutput("unused_stall", {31'd0, stall_id}, 32'd0);
    applyStimulus();

    // Flush overrides a pending stall
    set_writer(5'd3);
    set_reader(5'd3, 1, 5'd0, 0);
    ex_flush = 1;
    cnt0 = m_stalls;
    #1;
    checkOutput("flush_stall", {31'd0, stall_id}, 32'd0);
    applyStimulus();
    checkOutput("flush_valid", {31'd0, ex_valid}, 32'd0);
    checkOutput("flush_cnt", {16'd0, stall_cnt}, 32'(cnt0));

    // Asynchronous reset in the middle of a stall
    set_writer(5'd3);
    set_reader(5'd3, 1, 5'd0, 0);
    #2;
    checkOutput("pre_reset_stall", {31'd0, stall_id}, 32'd1);
    reset = 1;
    #1;
    checkOutput("areset_stall", {31'd0, stall_id}, 32'd0);
    checkOutput("areset_ctl", {29'd0, ex_valid, ex_reg_write, ex_mem_read}, 32'd0);
    checkOutput("areset_pc", ex_pc, 32'd0);
    checkOutput("areset_data", ex_rs1_data | ex_rs2_data | ex_imm, 32'd0);
    checkOutput("areset_fields", {11'd0, ex_ctrl, ex_rd}, 32'd0);
    checkOutput("areset_cnt", {16'd0, stall_cnt}, 32'd0);
    model_reset();
    @(posedge clk);
    @(negedge clk);
    reset = 0;
    applyStimulus();
    checkOutput("post_reset_accept", {31'd0, ex_valid}, 32'd1);

    // Randomized traffic against the model
    for (int i = 0; i < 400; i++) begin
      randomize_inputs();
      applyStimulus();
    end

    $display("%0d/%0d checks passed", checks_passed, checks_total);
    $finish;
  end

endmodule
